// File: rtl/synapse_mac_pkg.sv
// Shared types and helpers for the synapse MAC processing element.
// SYN_SATURATE_EN selects clamping instead of wrapping when narrowing results.
package synapse_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } syn_state_e;

    localparam int SYN_MAX_W = 128;

    // Full-precision accumulator: one product plus log2(depth) of headroom
    function automatic int syn_acc_w(input int dw, input int aw);
        return 2 * dw + aw;
    endfunction

    function automatic logic signed [SYN_MAX_W-1:0] syn_narrow(
        input logic signed [SYN_MAX_W-1:0] v,
        input int                          dw
    );
        logic signed [SYN_MAX_W-1:0] r;
`ifdef SYN_SATURATE_EN
        logic signed [SYN_MAX_W-1:0] one;
        logic signed [SYN_MAX_W-1:0] hi;
        logic signed [SYN_MAX_W-1:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (dw - 1)) - one;
        lo     = ~hi;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
`else
        // Keep the low dw bits, sign-extended (two's-complement wrap)
        r = (v <<< (SYN_MAX_W - dw)) >>> (SYN_MAX_W - dw);
`endif
        return r;
    endfunction

endpackage

// File: rtl/synapse_mac_wmem.sv
// Weight store: one synchronous write port, one combinational read port.
// No reset, so weights survive a PE reset.
module syn_wmem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write to rd_addr shows the old weight until the edge
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/synapse_mac.sv
// Synapse processing element: streams activations against stored weights.
// Build with SYN_SATURATE_EN to clamp results instead of wrapping them.
module synapse_mac
    import synapse_mac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [4:0]        cfg_shift,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam int ACC_W  = syn_acc_w(DATA_W, ADDR_W);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_ONE = 1;

    syn_state_e               state_q, state_d;
    logic [ADDR_W:0]          len_q, len_d;
    logic [4:0]               shift_q, shift_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0]        prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic                     fwd_valid_q, fwd_valid_d;
    logic [DATA_W-1:0]        fwd_data_q, fwd_data_d;

    logic [DATA_W-1:0]        w_rd;
    logic                     hs;
    logic                     last;
    logic [PROD_W-1:0]        a_x;
    logic [PROD_W-1:0]        w_x;
    logic [ACC_W-1:0]         prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic [SYN_MAX_W-1:0]     out_wide;

    syn_wmem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wmem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (w_rd)
    );

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign hs        = in_valid & in_ready;
    assign last      = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // Sign-extend operands so the low PROD_W bits are the signed product
    assign a_x      = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_x      = {{DATA_W{w_rd[DATA_W-1]}}, w_rd};
    assign prod_ext = {{ADDR_W{prod_q[PROD_W-1]}}, prod_q};

    assign shifted  = acc_q >>> shift_q;
    assign out_wide = {{(SYN_MAX_W - ACC_W){shifted[ACC_W-1]}}, shifted};
    assign out_data = out_valid ? DATA_W'(syn_narrow(out_wide, DATA_W)) : '0;

    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        fwd_valid_d = hs;
        fwd_data_d  = hs ? in_data : fwd_data_q;
        if (prod_vld_q) begin
            acc_d = acc_q + prod_ext;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    shift_d = cfg_shift;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = (cfg_len == '0) ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (hs) begin
                    prod_d     = a_x * w_x;
                    prod_vld_d = 1'b1;
                    idx_d      = idx_q + IDX_ONE;
                    if (last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

endmodule

// File: tb/tb_synapse_mac.sv
// Randomized bench for synapse_mac against a plain sum-of-products model.
// Honours SYN_SATURATE_EN the same way the design does.
module tb_synapse_mac;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   cfg_len = '0;
    logic [4:0]    cfg_shift = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          fwd_valid;
    logic [DW-1:0] fwd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    int wm [64];
    int acts [64];
    int exp_fd = 0;

    synapse_mac #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fwd_valid (fwd_valid),
        .fwd_data  (fwd_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Result = sum of products, arithmetic shift, then narrow to DW bits
    function automatic longint model(input longint sum, input int sh);
        longint v;
        v = sum >>> sh;
`ifdef SYN_SATURATE_EN
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`else
        v = v & 255;
        if (v > 127) v = v - 256;
`endif
        return v;
    endfunction

    task automatic wr_w(input int a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        wm[a]   = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) begin
            wr_w(i, i + 1);
            acts[i] = i + 5;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_in_ready"}, longint'(in_ready), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_out_data"}, sx(out_data), 0);
        check({tag, "_fwd_valid"}, longint'(fwd_valid), 0);
        check({tag, "_fwd_data"}, sx(fwd_data), 0);
    endtask

    task automatic run_job(input int len, input int sh, input int gap_pct,
                           input int hold, input bit mid_start, input int haz_k,
                           input bit has_fix, input longint fix);
        longint sum;
        longint expv;
        int     k;
        int     cyc;
        bit     hs;
        sum = 0;
        k   = 0;
        cyc = 0;
        @(negedge clk);
        start     = 1'b1;
        cfg_len   = (AW + 1)'(len);
        cfg_shift = 5'(sh);
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", longint'(busy), 1);
        while (k < len && cyc < 1000) begin
            check("in_ready_acc", longint'(in_ready), 1);
            check("out_valid_acc", longint'(out_valid), 0);
            if (mid_start && k == 1) begin
                start     = 1'b1;
                cfg_len   = 7'd1;
                cfg_shift = 5'd3;
            end
            in_valid = ($urandom_range(99) >= 32'(gap_pct));
            in_data  = in_valid ? DW'(acts[k]) : DW'($urandom);
            hs       = in_valid;
            if (hs) begin
                sum = sum + longint'(acts[k]) * longint'(wm[k]);
                if (haz_k == k) begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(k);
                    wr_data = 8'd100;
                    wm[k]   = 100;
                end
                exp_fd = acts[k];
                k++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            wr_en    = 1'b0;
            check("fwd_valid", longint'(fwd_valid), longint'(hs));
            check("fwd_data", sx(fwd_data), longint'(exp_fd));
            cyc++;
        end
        if (k < len) begin
            check("accept_timeout", k, len);
        end
        if (len > 0) begin
            check("in_ready_flush", longint'(in_ready), 0);
            check("out_valid_flush", longint'(out_valid), 0);
            @(negedge clk);
            check("fwd_valid_idle", longint'(fwd_valid), 0);
            check("fwd_data_hold", sx(fwd_data), longint'(exp_fd));
        end
        expv = model(sum, sh);
        check("out_valid_lat", longint'(out_valid), 1);
        check("out_data", sx(out_data), expv);
        if (has_fix) begin
            check("out_data_fixed", sx(out_data), fix);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("out_valid_hold", longint'(out_valid), 1);
            check("out_data_hold", sx(out_data), expv);
            check("in_ready_out", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_done", longint'(out_valid), 0);
        check("busy_done", longint'(busy), 0);
    endtask

    initial begin
        longint sat_a;
        longint sat_b;
        int     len;
        for (int i = 0; i < 64; i++) begin
            wm[i]   = 0;
            acts[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        load_basic();
        run_job(4, 0, 0, 0, 1'b0, -1, 1'b1, 70);
        run_job(4, 2, 0, 1, 1'b0, -1, 1'b1, 17);
        run_job(4, 0, 40, 5, 1'b0, -1, 1'b1, 70);
        run_job(4, 0, 20, 2, 1'b1, -1, 1'b1, 70);
        run_job(0, 0, 0, 2, 1'b0, -1, 1'b1, 0);
        run_job(4, 0, 0, 0, 1'b0, 2, 1'b1, 70);
        run_job(4, 0, 0, 0, 1'b0, -1, 1'b0, 0);

`ifdef SYN_SATURATE_EN
        sat_a = 127;
        sat_b = -128;
`else
        sat_a = 4;
        sat_b = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            wr_w(i, 127);
            acts[i] = 127;
        end
        run_job(4, 0, 0, 0, 1'b0, -1, 1'b1, sat_a);
        for (int i = 0; i < 2; i++) begin
            wr_w(i, -128);
        end
        run_job(2, 0, 10, 1, 1'b0, -1, 1'b1, sat_b);

        load_basic();
        @(negedge clk);
        start   = 1'b1;
        cfg_len = 7'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(acts[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst    = 1'b0;
        exp_fd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_out_after_reset", longint'(out_valid), 0);
        end
        run_job(4, 0, 0, 0, 1'b0, -1, 1'b1, 70);

        for (int j = 0; j < 8; j++) begin
            len = int'($urandom_range(64, 1));
            for (int i = 0; i < len; i++) begin
                wr_w(i, int'($urandom_range(255)) - 128);
                acts[i] = int'($urandom_range(255)) - 128;
            end
            run_job(len, int'($urandom_range(12)), 30,
                    int'($urandom_range(3)), 1'b0, -1, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/synapse_mac.md
SYNAPSE_MAC -- requirements
Module: synapse_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed activation/weight/result width.
REQ-002 SHALL have parameter ADDR_W, default 6: weight memory depth 2**ADDR_W.
REQ-003 SHALL have ports clk (in, 1: clock) and rst (in, 1: reset, synchronous, active-high); all state changes on posedge clk.
REQ-004 SHALL have ports wr_en (in, 1), wr_addr (in, ADDR_W), wr_data (in, DATA_W): weight write.
REQ-005 SHALL have ports start (in, 1), cfg_len (in, ADDR_W+1: products per result), cfg_shift (in, 5: result right-shift).
REQ-006 SHALL have ports in_valid (in, 1), in_data (in, DATA_W), in_ready (out, 1): activation stream.
REQ-007 SHALL have ports fwd_valid (out, 1) and fwd_data (out, DATA_W): registered activation forward to the neighbour PE.
REQ-008 SHALL have ports out_valid (out, 1), out_data (out, DATA_W), out_ready (in, 1): result stream.
REQ-009 SHALL have port busy (out, 1), high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM IDLE, ACC, FLUSH, OUT.
REQ-011 IDLE: in_ready=0; start=1 SHALL latch cfg_len and cfg_shift, clear acc and idx, go to ACC; if cfg_len=0, go directly to OUT with result 0.
REQ-012 ACC: in_ready=1; in_valid&in_ready SHALL register product in_data*W[idx] (signed, 2*DATA_W bits) and increment idx.
REQ-013 The registered product SHALL be added to acc one cycle later; acc width 2*DATA_W+ADDR_W, signed, no internal overflow.
REQ-014 On the handshake with idx=len-1, ACC SHALL go to FLUSH and drop in_ready; FLUSH lasts 1 cycle, then OUT.
REQ-015 Latency: handshake of the last activation in cycle T SHALL give out_valid=1 from cycle T+2.
REQ-016 OUT: out_valid=1, out_data stable; on out_ready=1 SHALL go to IDLE. Output SHALL be held indefinitely while out_ready=0.
REQ-017 out_data SHALL be acc arithmetically shifted right by cfg_shift, then narrowed per REQ-026/027.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 Weight read SHALL be combinational at idx. A write to the address being read in the same cycle SHALL return the old weight; the new value SHALL be visible next cycle.
REQ-020 Weight writes SHALL be accepted in every state.
REQ-021 fwd_valid/fwd_data SHALL equal the values of (in_valid&in_ready)/in_data one cycle earlier; fwd_data SHALL hold its value when fwd_valid=0.
REQ-022 Gaps in in_valid SHALL stall idx and acc without loss.

Reset
REQ-023 rst SHALL force IDLE, idx=0, acc=0, product reg=0, in_ready=0, fwd_valid=0, fwd_data=0, out_valid=0, out_data=0, busy=0.
REQ-024 Reset mid-operation SHALL abandon the partial sum with no out_valid pulse; weight memory SHALL NOT be cleared.
REQ-025 Weight memory SHALL have no reset.

Configuration
REQ-026 Macro SYN_SATURATE_EN defined: a shifted value outside the signed DATA_W range SHALL clamp to 2**(DATA_W-1)-1 or -2**(DATA_W-1).
REQ-027 SYN_SATURATE_EN undefined: the shifted value SHALL be truncated to its low DATA_W bits (two's-complement wrap).

Structure
REQ-028 The shared package SHALL hold the FSM state enum, the ACC_W derivation function, and the saturation/narrowing function.
REQ-029 Weight storage SHALL be sub-module syn_wmem (1 write port, 1 async read port, parameters DATA_W and ADDR_W); the FSM, MAC, and forwarding logic SHALL stay in synapse_mac.

Verification
REQ-030 Basic MAC, DATA_W=8: W={1,2,3,4}, acts {5,6,7,8}, len=4, shift=0 -> out_data=70, out_valid exactly 2 cycles after the 4th handshake.
REQ-031 Saturation, DATA_W=8: W=127 x4, acts 127 x4, shift=0 -> 127 with SYN_SATURATE_EN; 4 without it (64516 mod 256). W=-128 x2, acts 127 x2 -> -128 with SYN_SATURATE_EN.
REQ-032 Shift: Basic MAC stimulus with shift=2 -> out_data=17.
REQ-033 Handshakes: random in_valid gaps plus out_ready held low 5 cycles -> same result, out_data stable throughout, in_ready=0 in FLUSH/OUT, fwd mirrors accepted data with 1-cycle delay.
REQ-034 Hazards: start during ACC ignored; len=0 -> out_valid with 0; write to W[idx] in the handshake cycle uses the old weight.
REQ-035 Reset mid-ACC after 2 of 4 products -> all outputs 0 next cycle, no out_valid; a rerun without reloading weights gives 70.
